// File: rtl/flash_read_bridge_if.sv
// flash_read_bridge_if: request/response bundle between the SoC-side flash port and the
// flash read bridge.
//   req_*  : burst read request (valid/ready), master -> bridge
//   resp_* : ordered response beats (valid/ready), bridge -> master
// Optional: req_wrap exists only when FLASH_BRIDGE_WRAP_EN is defined.
interface flash_read_bridge_if #(
    parameter int unsigned ID_W = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [7:0]      req_len;
    logic [ID_W-1:0] req_id;
`ifdef FLASH_BRIDGE_WRAP_EN
    logic            req_wrap;
`endif
    logic            resp_valid;
    logic            resp_ready;
    logic [63:0]     resp_data;
    logic [ID_W-1:0] resp_id;
    logic            resp_err;
    logic            resp_last;

`ifdef FLASH_BRIDGE_WRAP_EN
    modport master (
        output req_valid, req_addr, req_len, req_id, req_wrap, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err, resp_last
    );
    modport slave (
        input  req_valid, req_addr, req_len, req_id, req_wrap, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err, resp_last
    );
`else
    modport master (
        output req_valid, req_addr, req_len, req_id, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err, resp_last
    );
    modport slave (
        input  req_valid, req_addr, req_len, req_id, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err, resp_last
    );
`endif
endinterface

// File: rtl/flash_read_bridge.sv
// flash_read_bridge: splits burst read requests into 8-byte beats on a 64-bit flash model
// (addr/ren, 1-cycle read latency) and returns ordered beats through a credit-controlled
// response FIFO.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (slave) : req_* burst request handshake, resp_* response beats (see flash_read_bridge_if)
//   flash_addr  : byte offset into flash, 8-byte aligned
//   flash_ren   : flash read enable, one beat per cycle
//   flash_data  : read data, valid the cycle after flash_ren
// Build option: define FLASH_BRIDGE_WRAP_EN to enable wrap bursts via bus.req_wrap.
module flash_read_bridge #(
    parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
    parameter int unsigned FLASH_SIZE = 8192,
    parameter int unsigned RESP_DEPTH = 2,
    parameter int unsigned ID_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    flash_read_bridge_if.slave bus,
    output logic [31:0]        flash_addr,
    output logic               flash_ren,
    input  logic [63:0]        flash_data
);
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [32:0] LIMIT = {1'b0, FLASH_BASE} + 33'(FLASH_SIZE);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    typedef struct packed {
        logic [63:0]     data;
        logic [ID_W-1:0] id;
        logic            err;
        logic            last;
    } entry_t;

    // Burst state
    state_e          state_q;
    logic [31:0]     addr_q;       // address of the next beat to issue
    logic [31:0]     mask_q;       // address bits that advance; bits outside stay fixed (wrap)
    logic [8:0]      left_q;       // beats still to issue
    logic [ID_W-1:0] id_q;
    logic            force_err_q;  // illegal wrap length: every beat errors
    logic [31:0]     flash_addr_q;

    // Read pipeline: sideband travelling alongside the flash read
    logic            inflight_q;
    logic            p_err_q;
    logic            p_last_q;
    logic [ID_W-1:0] p_id_q;

    // Response FIFO
    entry_t           mem_q [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic        accept;
    logic        pop;
    logic        push;
    logic        issue;
    logic        in_range;
    logic        last_beat;
    logic [31:0] occ;
    logic [32:0] beat_end;
    logic [31:0] next_addr;
    logic [31:0] start_addr;
    logic [8:0]  req_beats;
    entry_t      head;
    entry_t      push_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == RESP_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.req_ready = rst_n && (state_q == StIdle);
    assign accept        = bus.req_valid && bus.req_ready;
    assign start_addr    = bus.req_addr & ~32'h7;
    assign req_beats     = {1'b0, bus.req_len} + 9'd1;

    // Credit: FIFO occupancy plus the read still in the pipe, minus this cycle's pop, must
    // leave room for one more beat.
    assign pop       = bus.resp_valid && bus.resp_ready;
    assign push      = inflight_q;
    assign occ       = 32'(count_q) + 32'(inflight_q) - 32'(pop);
    assign issue     = rst_n && (state_q == StBurst) && (occ < RESP_DEPTH);
    assign last_beat = (left_q == 9'd1);

    assign beat_end  = {1'b0, addr_q} + 33'd8;
    assign in_range  = !force_err_q && (addr_q >= FLASH_BASE) && (beat_end <= LIMIT);
    assign next_addr = (addr_q & ~mask_q) | ((addr_q + 32'd8) & mask_q);

    assign flash_ren  = issue && in_range;
    assign flash_addr = flash_ren ? (addr_q - FLASH_BASE) : flash_addr_q;

    always_comb begin
        push_entry      = '0;
        push_entry.data = p_err_q ? 64'd0 : flash_data;
        push_entry.id   = p_id_q;
        push_entry.err  = p_err_q;
        push_entry.last = p_last_q;
    end

    // Outputs are gated by valid so an empty FIFO presents all zeros.
    assign head           = mem_q[rd_ptr_q];
    assign bus.resp_valid = (count_q != '0);
    assign bus.resp_data  = bus.resp_valid ? head.data : '0;
    assign bus.resp_id    = bus.resp_valid ? head.id : '0;
    assign bus.resp_err   = bus.resp_valid && head.err;
    assign bus.resp_last  = bus.resp_valid && head.last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            mask_q       <= '1;
            left_q       <= '0;
            id_q         <= '0;
            force_err_q  <= 1'b0;
            flash_addr_q <= '0;
            inflight_q   <= 1'b0;
            p_err_q      <= 1'b0;
            p_last_q     <= 1'b0;
            p_id_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                state_q     <= StBurst;
                addr_q      <= start_addr;
                left_q      <= req_beats;
                id_q        <= bus.req_id;
                mask_q      <= '1;
                force_err_q <= 1'b0;
`ifdef FLASH_BRIDGE_WRAP_EN
                if (bus.req_wrap) begin
                    if (req_beats == 9'd2 || req_beats == 9'd4 ||
                        req_beats == 9'd8 || req_beats == 9'd16) begin
                        mask_q <= (32'(req_beats) << 3) - 32'd1;
                    end else begin
                        force_err_q <= 1'b1;
                    end
                end
`endif
            end else if (issue) begin
                addr_q <= next_addr;
                left_q <= left_q - 9'd1;
                if (last_beat) begin
                    state_q <= StIdle;
                end
            end

            inflight_q <= issue;
            p_err_q    <= !in_range;
            p_last_q   <= last_beat;
            p_id_q     <= id_q;

            if (flash_ren) begin
                flash_addr_q <= flash_addr;
            end

            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: doc/flash_read_bridge.md
Name: flash_read_bridge

Overview:
- Upstream request/response front end that feeds the 64-bit simulation flash model.
- Accepts burst read requests from the SoC-side flash port and splits them into 8-byte flash beats on the flash model's addr/ren interface.
- Absorbs the model's fixed 1-cycle read latency and returns ordered beats through a small credit-controlled response FIFO with valid/ready backpressure.
- Out-of-range beats return an error flag and issue no flash read.

Parameters:
FLASH_BASE, 32'h1000_0000, byte address at which flash offset 0 is mapped
FLASH_SIZE, 8192, flash size in bytes (multiple of 8)
RESP_DEPTH, 2, response FIFO entries (>=2)
ID_W, 4, request/response ID width

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  32  start byte address; bits [2:0] ignored (aligned down)
req_len  in  8  beats minus one (1..256 beats)
req_id  in  ID_W  tag echoed on every beat
req_wrap  in  1  wrap burst select (present only with FLASH_BRIDGE_WRAP_EN)
flash_addr  out  32  byte offset into flash, bits [2:0] always 0
flash_ren  out  1  flash read enable, one beat per cycle high
flash_data  in  64  flash read data, valid the cycle after flash_ren
resp_valid  out  1  response beat valid
resp_ready  in  1  response beat accepted
resp_data  out  64  beat data (0 on error)
resp_id  out  ID_W  req_id of owning burst
resp_err  out  1  beat address out of range
resp_last  out  1  final beat of burst

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, FIFO emptied, in-flight read discarded. Outputs: req_ready=0 while rst_n low, resp_valid=0, flash_ren=0, flash_addr=0, resp_data/resp_id/resp_err/resp_last=0. A reset asserted mid-burst drops all pending beats; no response is produced for them.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch aligned address, beat count = req_len+1, id, and mode; go to BURST.
  - BURST: req_ready=0. Issue one beat per cycle when credit allows. After the final beat is issued, go to IDLE. Next request may be accepted while earlier beats still drain; ordering is preserved.
- Credit rule: a beat issues in a cycle iff count + inflight - (resp_valid&resp_ready) < RESP_DEPTH, where inflight=1 if a beat was issued last cycle.
- Beat issue:
  - Beat address a = base + 8*k (INCR), 32-bit wrap-around on overflow.
  - In range when FLASH_BASE <= a and a+8 <= FLASH_BASE+FLASH_SIZE. Then flash_ren=1 and flash_addr=a-FLASH_BASE.
  - Out of range: flash_ren=0 and flash_addr holds its previous value. The beat still occupies a pipeline slot with err=1.
  - Beat sideband (err, last, id) is pipelined 1 cycle alongside the read.
- Capture: in the cycle after issue, push {in-range ? flash_data : 0, id, err, last} into the FIFO.
- Response: resp_* driven from the FIFO head, registered. Simultaneous push and pop are allowed, including at full (credit guarantees no overflow).
- Latency: with the request accepted in cycle 0 and resp_ready=1, flash_ren is high in cycle 1, resp_valid is first high in cycle 3, and throughput is 1 beat/cycle. flash_ren is never high while stalled.
- flash_ren deasserts whenever no beat issues; the flash model holds its data, which the bridge never re-samples.

Optional Feature:
- Macro FLASH_BRIDGE_WRAP_EN.
- Defined:
  - req_wrap port exists and is latched at accept.
  - Wrap burst: beats must be 2, 4, 8 or 16. Addresses wrap within the aligned (beats*8)-byte window, starting at req_addr[...:3].
  - Wrap with any other length: all beats err=1, no flash reads, resp_last still on the final beat.
- Undefined: port absent, INCR only.

Test Plan:
- Single beat: reset, req_addr=0x1000_0008, len=0, id=3 -> flash_ren cycle 1 with flash_addr=0x8; resp_valid cycle 3 with model data, id=3, last=1, err=0.
- Full-rate burst: addr 0x1000_0000, len=7, resp_ready=1 -> flash_addr 0x0..0x38 step 8 on consecutive cycles; 8 responses back-to-back, last only on the 8th.
- Backpressure: len=3, resp_ready=0 from cycle 0 -> at most RESP_DEPTH(2) reads issued, then flash_ren stays 0. Releasing ready delivers all 4 beats in order with no loss or duplication.
- Range edge: addr 0x1000_1FF8, len=1 -> beat 0 reads offset 0x1FF8 with err=0; beat 1 has flash_ren=0 and resp_data=0, err=1, last=1.
- Reset mid-burst: len=15, assert rst_n=0 after 5 responses -> next cycle resp_valid=0, flash_ren=0. After release, a new request gets only its own beats.
- Wrap (macro on): addr 0x1000_0018, len=3, wrap=1 -> flash_addr 0x18, 0x00, 0x08, 0x10. With len=2 and wrap=1 -> 3 err beats, no flash_ren.
